// File: rtl/axi_arbiter_w.sv
// Write-channel arbiter: grants one of four AXI masters access to the DDR
// controller for one complete write burst (AW handshake plus all W beats).
// Optional build macro AXI_ARB_W_ROUND_ROBIN_EN selects round-robin arbitration
// starting after the last-granted master; without it, fixed priority s0 > s1 > s2 > s3.
module axi_arbiter_w #(
  parameter int unsigned LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s0_AWVALID,
  input  logic                 s1_AWVALID,
  input  logic                 s2_AWVALID,
  input  logic                 s3_AWVALID,
  input  logic                 axi_awvalid,
  input  logic                 axi_awready,
  input  logic [LEN_WIDTH-1:0] axi_awlen,
  input  logic                 axi_wready,
  output logic                 s0_wgrnt,
  output logic                 s1_wgrnt,
  output logic                 s2_wgrnt,
  output logic                 s3_wgrnt,
  output logic [1:0]           wr_grnt_id,
  output logic                 wr_busy,
  output logic                 wr_done
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e               state_q, state_d;
  logic [3:0]           grant_q, grant_d;
  logic [1:0]           gid_q, gid_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  // Low for the first edge after reset release so no grant lands on that edge.
  logic                 en_q, en_d;

  logic [3:0] req;
  logic [1:0] pick_idx;
  logic       pick_vld;
  logic [1:0] cand;

  assign req = {s3_AWVALID, s2_AWVALID, s1_AWVALID, s0_AWVALID};

  // Select the winning requester.
  always_comb begin
    pick_idx = 2'd0;
    pick_vld = 1'b0;
    cand     = 2'd0;
`ifdef AXI_ARB_W_ROUND_ROBIN_EN
    // Search last-granted+1 upward; offset 4 wraps back to the pointer itself.
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
`else
    // Descending scan so the lowest index wins.
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        pick_vld = 1'b1;
        pick_idx = 2'(i);
      end
    end
`endif
  end

  // Next-state and datapath updates for the burst FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    en_d    = 1'b1;
    unique case (state_q)
      StIdle: begin
        grant_d = 4'b0000;
        gid_d   = 2'd0;
        if (en_q && pick_vld) begin
          grant_d = 4'b0001 << pick_idx;
          gid_d   = pick_idx;
          state_d = StAddr;
        end
      end
      StAddr: begin
        // Grant is held regardless of the master's AWVALID until the handshake.
        if (axi_awvalid && axi_awready) begin
          len_d   = axi_awlen;
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (axi_wready) begin
          if (cnt_q == len_q) begin
            done_d  = 1'b1;
            grant_d = 4'b0000;
            gid_d   = 2'd0;
            ptr_d   = gid_q;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 4'b0000;
        gid_d   = 2'd0;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= 4'b0000;
      gid_q   <= 2'd0;
      ptr_q   <= 2'd3;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      en_q    <= en_d;
    end
  end

  assign s0_wgrnt   = grant_q[0];
  assign s1_wgrnt   = grant_q[1];
  assign s2_wgrnt   = grant_q[2];
  assign s3_wgrnt   = grant_q[3];
  assign wr_grnt_id = gid_q;
  assign wr_busy    = (state_q != StIdle);
  assign wr_done    = done_q;

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Directed testbench for axi_arbiter_w; expectations follow the build macro
// AXI_ARB_W_ROUND_ROBIN_EN so the same bench serves both arbitration modes.
module tb_axi_arbiter_w;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_awvalid = 4'b0000;
  logic       axi_awvalid = 1'b0;
  logic       axi_awready = 1'b0;
  logic [3:0] axi_awlen = 4'd0;
  logic       axi_wready = 1'b0;
  logic [3:0] s_wgrnt;
  logic [1:0] wr_grnt_id;
  logic       wr_busy;
  logic       wr_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_arbiter_w #(
    .LEN_WIDTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s0_AWVALID (s_awvalid[0]),
    .s1_AWVALID (s_awvalid[1]),
    .s2_AWVALID (s_awvalid[2]),
    .s3_AWVALID (s_awvalid[3]),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_awlen  (axi_awlen),
    .axi_wready (axi_wready),
    .s0_wgrnt   (s_wgrnt[0]),
    .s1_wgrnt   (s_wgrnt[1]),
    .s2_wgrnt   (s_wgrnt[2]),
    .s3_wgrnt   (s_wgrnt[3]),
    .wr_grnt_id (wr_grnt_id),
    .wr_busy    (wr_busy),
    .wr_done    (wr_done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    s_awvalid   = 4'b0000;
    axi_awvalid = 1'b0;
    axi_awready = 1'b0;
    axi_awlen   = 4'd0;
    axi_wready  = 1'b0;
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_order[5];
  int got[5];

  initial begin
`ifdef AXI_ARB_W_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif

    // Reset state
    #1;
    repeat (2) step();
    check("rst_grant", 32'(s_wgrnt), 32'h0);
    check("rst_id", 32'(wr_grnt_id), 32'h0);
    check("rst_busy", 32'(wr_busy), 32'h0);
    check("rst_done", 32'(wr_done), 32'h0);

    // Single request s2, awlen=3, AW handshake in the second grant cycle
    begin
      int grant_cycles = 0;
      int done_cnt = 0;
      int done_at = -1;
      int id_bad = 0;
      logic busy_at_done = 1'b1;
      logic [3:0] grant_at_done = 4'hf;
      apply_reset();
      s_awvalid   = 4'b0100;
      axi_awvalid = 1'b1;
      axi_awlen   = 4'd3;
      axi_wready  = 1'b1;
      step();
      check("t1_no_grant_edge1", 32'(s_wgrnt), 32'h0);
      step();
      check("t1_grant", 32'(s_wgrnt), 32'h4);
      check("t1_id", 32'(wr_grnt_id), 32'h2);
      check("t1_busy", 32'(wr_busy), 32'h1);
      s_awvalid = 4'b0000;  // grant must persist without the request
      for (int i = 0; i < 10; i++) begin
        if (s_wgrnt == 4'b0100) begin
          grant_cycles++;
          if (wr_grnt_id != 2'd2) id_bad++;
        end
        if (wr_done) begin
          done_cnt++;
          done_at       = i;
          busy_at_done  = wr_busy;
          grant_at_done = s_wgrnt;
        end
        axi_awready = (i == 1);
        step();
      end
      check("t1_grant_cycles", 32'(grant_cycles), 32'd6);
      check("t1_id_hold", 32'(id_bad), 32'd0);
      check("t1_done_cnt", 32'(done_cnt), 32'd1);
      check("t1_done_at", 32'(done_at), 32'd6);
      check("t1_busy_at_done", 32'(busy_at_done), 32'h0);
      check("t1_grant_at_done", 32'(grant_at_done), 32'h0);
    end

    // All four requests held, awlen=0: grant order and idle gap
    begin
      int n_got = 0;
      int idle_run = 0;
      int gap_err = 0;
      int onehot_err = 0;
      int id_err = 0;
      logic [3:0] prev = 4'b0000;
      apply_reset();
      s_awvalid   = 4'b1111;
      axi_awvalid = 1'b1;
      axi_awready = 1'b1;
      axi_awlen   = 4'd0;
      axi_wready  = 1'b1;
      for (int c = 0; c < 60 && n_got < 5; c++) begin
        step();
        if ($countones(s_wgrnt) > 1) onehot_err++;
        if (s_wgrnt != 4'b0000 && prev == 4'b0000) begin
          got[n_got] = int'(wr_grnt_id);
          if (s_wgrnt != (4'b0001 << wr_grnt_id)) id_err++;
          if (n_got > 0 && idle_run != 1) gap_err++;
          n_got++;
        end
        idle_run = (s_wgrnt == 4'b0000) ? idle_run + 1 : 0;
        prev = s_wgrnt;
      end
      check("t2_n_grants", 32'(n_got), 32'd5);
      for (int k = 0; k < 5; k++) begin
        check($sformatf("t2_order%0d", k), 32'(got[k]), 32'(exp_order[k]));
      end
      check("t2_idle_gap", 32'(gap_err), 32'd0);
      check("t2_onehot", 32'(onehot_err), 32'd0);
      check("t2_id_match", 32'(id_err), 32'd0);
    end

    // awlen=15 with wready toggling; wready outside DATA must be ignored
    begin
      int highs = 0;
      int early = 0;
      logic done_seen = 1'b0;
      apply_reset();
      s_awvalid   = 4'b0010;
      axi_awvalid = 1'b1;
      axi_awready = 1'b1;
      axi_awlen   = 4'd15;
      axi_wready  = 1'b1;
      step();
      check("t3_no_grant_edge1", 32'(s_wgrnt), 32'h0);
      step();
      check("t3_grant", 32'(s_wgrnt), 32'h2);
      step();
      s_awvalid   = 4'b0000;
      axi_awvalid = 1'b0;
      axi_awready = 1'b0;
      for (int k = 0; k < 80 && !done_seen; k++) begin
        axi_wready = (k % 2 == 0);
        if (axi_wready) highs++;
        step();
        if (wr_done) done_seen = 1'b1;
        else if (s_wgrnt != 4'b0010) early++;
      end
      check("t3_done_seen", 32'(done_seen), 32'h1);
      check("t3_high_beats", 32'(highs), 32'd16);
      check("t3_no_early_release", 32'(early), 32'd0);
      check("t3_grant_cleared", 32'(s_wgrnt), 32'h0);
      axi_wready = 1'b0;
      step();
      check("t3_done_pulse_len", 32'(wr_done), 32'h0);
    end

    // Reset asserted mid-DATA at beat 2 of 8
    begin
      int done_cnt = 0;
      apply_reset();
      s_awvalid   = 4'b1000;
      axi_awvalid = 1'b1;
      axi_awready = 1'b1;
      axi_awlen   = 4'd7;
      axi_wready  = 1'b0;
      step();
      step();
      check("t4_grant", 32'(s_wgrnt), 32'h8);
      check("t4_id", 32'(wr_grnt_id), 32'h3);
      step();
      s_awvalid  = 4'b0000;
      axi_wready = 1'b1;
      step();
      if (wr_done) done_cnt++;
      step();
      if (wr_done) done_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      check("t4_async_grant", 32'(s_wgrnt), 32'h0);
      check("t4_async_busy", 32'(wr_busy), 32'h0);
      check("t4_async_id", 32'(wr_grnt_id), 32'h0);
      check("t4_async_done", 32'(wr_done), 32'h0);
      s_awvalid  = 4'b1111;
      axi_awlen  = 4'd0;
      step();
      if (wr_done) done_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      if (wr_done) done_cnt++;
      check("t4_no_grant_edge1", 32'(s_wgrnt), 32'h0);
      step();
      if (wr_done) done_cnt++;
      check("t4_first_grant", 32'(s_wgrnt), 32'h1);
      check("t4_first_id", 32'(wr_grnt_id), 32'h0);
      check("t4_no_done", 32'(done_cnt), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
